// File: rtl/enc_quad_counter.sv
// enc_quad_counter: quadrature decode and detent counter for the rotary encoder.
// Synchronizes the debounced A/B/button levels, decodes quadrature steps into a
// sub-detent accumulator, and produces a signed position, last direction,
// one-cycle step/button ticks and a sticky illegal-transition flag.
module enc_quad_counter #(
    parameter int CNT_W            = 16,
    parameter int STEPS_PER_DETENT = 4,
    parameter int WRAP             = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_in,
    input  logic                    b_in,
    input  logic                    btn_in,
    input  logic                    clr,
    input  logic                    err_clr,
    output logic signed [CNT_W-1:0] pos,
    output logic                    dir,
    output logic                    step_tick,
    output logic                    btn_tick,
    output logic                    err
);

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] POS_ONE = CNT_W'(1);
    localparam logic signed [3:0]       STEP_P  = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0]       STEP_N  = -STEP_P;

    // bit 0 is the first synchronizer stage, bit 1 the stage actually used
    logic [1:0]       a_sync;
    logic [1:0]       b_sync;
    logic [1:0]       btn_sync;

    state_t           state;
    logic [1:0]       prime_cnt;
    logic [1:0]       q_prev;
    logic             btn_prev;
    logic signed [3:0] acc;

    logic [1:0]       q;
    logic [1:0]       delta;
    logic             mv_cw;
    logic             mv_ccw;
    logic             mv_bad;
    logic signed [3:0] acc_inc;
    logic signed [3:0] acc_dec;
    logic             hit_p;
    logic             hit_n;
    logic signed [CNT_W-1:0] pos_up;
    logic signed [CNT_W-1:0] pos_dn;

    // Map the Gray-coded quadrature state to its position in the CW cycle
    function automatic logic [1:0] gray_idx(input logic [1:0] g);
        case (g)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Two-flop synchronizers for the asynchronous encoder levels
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_sync   <= 2'b00;
            b_sync   <= 2'b00;
            btn_sync <= 2'b00;
        end else begin
            a_sync   <= {a_sync[0], a_in};
            b_sync   <= {b_sync[0], b_in};
            btn_sync <= {btn_sync[0], btn_in};
        end
    end

    // Step decode: modulo-4 distance in the CW cycle, 1 = CW, 3 = CCW, 2 = skipped state
    always_comb begin
        q       = {a_sync[1], b_sync[1]};
        delta   = gray_idx(q) - gray_idx(q_prev);
        mv_cw   = (state == RUN) && (delta == 2'd1);
        mv_ccw  = (state == RUN) && (delta == 2'd3);
        mv_bad  = (state == RUN) && (delta == 2'd2);
        acc_inc = acc + 4'sd1;
        acc_dec = acc - 4'sd1;
        hit_p   = mv_cw  && (acc_inc == STEP_P);
        hit_n   = mv_ccw && (acc_dec == STEP_N);
        // saturate at the signed limits unless wrapping is enabled
        if ((WRAP == 0) && (pos == POS_MAX)) pos_up = pos;
        else                                 pos_up = pos + POS_ONE;
        if ((WRAP == 0) && (pos == POS_MIN)) pos_dn = pos;
        else                                 pos_dn = pos - POS_ONE;
    end

    // Prime/run FSM with accumulator, position, ticks and sticky error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= PRIME;
            prime_cnt <= 2'd0;
            q_prev    <= 2'b00;
            btn_prev  <= 1'b0;
            acc       <= 4'sd0;
            pos       <= '0;
            dir       <= 1'b0;
            step_tick <= 1'b0;
            btn_tick  <= 1'b0;
            err       <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            btn_tick  <= 1'b0;

            case (state)
                PRIME: begin
                    // tracking the button here too means a press held through
                    // reset is already "seen" when RUN starts
                    btn_prev <= btn_sync[1];
                    if (prime_cnt == 2'd2) begin
                        q_prev <= q;
                        state  <= RUN;
                    end else begin
                        prime_cnt <= prime_cnt + 2'd1;
                    end
                end
                default: begin
                    q_prev   <= q;
                    btn_prev <= btn_sync[1];
                    btn_tick <= btn_sync[1] & ~btn_prev;
                    if (mv_bad) begin
                        acc <= 4'sd0;
                    end else if (hit_p) begin
                        acc       <= 4'sd0;
                        pos       <= pos_up;
                        dir       <= 1'b1;
                        step_tick <= 1'b1;
                    end else if (hit_n) begin
                        acc       <= 4'sd0;
                        pos       <= pos_dn;
                        dir       <= 1'b0;
                        step_tick <= 1'b1;
                    end else if (mv_cw) begin
                        acc <= acc_inc;
                    end else if (mv_ccw) begin
                        acc <= acc_dec;
                    end
                end
            endcase

            // a fresh illegal jump wins over a simultaneous clear request
            if (mv_bad)       err <= 1'b1;
            else if (err_clr) err <= 1'b0;

            // clear swallows any detent counted this cycle, including its dir update
            if (clr) begin
                pos       <= '0;
                acc       <= 4'sd0;
                step_tick <= 1'b0;
                dir       <= dir;
            end
        end
    end

endmodule
